// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter from the icache/dcache miss ports onto one main-memory line port.
// One transaction in flight at a time; WAIT is bounded by a timeout answered with a bus error.
module core_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         icache_req_valid_miss,
  input  logic [148:0] icache_req_info_miss,
  input  logic         dcache_req_valid_miss,
  input  logic [148:0] dcache_req_info_miss,
  output logic [127:0] rsp_data_miss,
  output logic         rsp_bus_error,
  output logic         rsp_valid_miss,
  output logic         rsp_cache_id,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic         mem_req_we,
  output logic [19:0]  mem_req_addr,
  output logic [127:0] mem_req_wdata,
  input  logic         mem_rsp_valid,
  input  logic [127:0] mem_rsp_data,
  input  logic         mem_rsp_error
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e       r_state;
  state_e       w_state_next;
  logic [1:0]   r_pend_vld;
  logic [148:0] r_pend_info [2];
  logic         r_last_grant;
  logic         r_act_id;
  logic [148:0] r_act_info;
  logic [CNT_W-1:0] r_cnt;
  logic [127:0] r_rsp_data;
  logic         r_rsp_err;
  logic         r_rsp_id;

  logic [1:0]   w_req_vld;
  logic [1:0]   w_inflight;
  logic [1:0]   w_capture;
  logic [1:0]   w_grant_oh;
  logic         w_grant;
  logic         w_grant_id;
  logic         w_accept;
  logic         w_rsp_take;
  logic         w_timeout;

  assign w_req_vld  = {dcache_req_valid_miss, icache_req_valid_miss};
  // The source being served keeps its level high until it sees its response; ignore it.
  assign w_inflight = (r_state == StIdle) ? 2'b00 : (r_act_id ? 2'b10 : 2'b01);
  assign w_capture  = w_req_vld & ~r_pend_vld & ~w_inflight;
  assign w_grant_oh = w_grant ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    w_state_next   = r_state;
    w_grant        = 1'b0;
    w_accept       = 1'b0;
    w_rsp_take     = 1'b0;
    w_timeout      = 1'b0;
    mem_req_valid  = 1'b0;
    rsp_valid_miss = 1'b0;
    w_grant_id     = (&r_pend_vld) ? ~r_last_grant : r_pend_vld[1];
    unique case (r_state)
      StIdle: begin
        if (|r_pend_vld) begin
          w_grant      = 1'b1;
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          w_accept     = 1'b1;
          w_state_next = StWait;
        end
      end
      StWait: begin
        // A response in the timeout cycle still wins.
        if (mem_rsp_valid) begin
          w_rsp_take   = 1'b1;
          w_state_next = StResp;
        end else if (r_cnt == CntLast) begin
          w_timeout    = 1'b1;
          w_state_next = StResp;
        end
      end
      StResp: begin
        rsp_valid_miss = 1'b1;
        w_state_next   = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend_vld     <= 2'b00;
      r_pend_info[0] <= '0;
      r_pend_info[1] <= '0;
      r_last_grant   <= 1'b1;
      r_act_id       <= 1'b0;
      r_act_info     <= '0;
      r_cnt          <= '0;
      r_rsp_data     <= '0;
      r_rsp_err      <= 1'b0;
      r_rsp_id       <= 1'b0;
    end else begin
      // Capture needs an empty latch and grant needs a full one, so they never collide.
      r_pend_vld <= (r_pend_vld & ~w_grant_oh) | w_capture;
      if (w_capture[0]) r_pend_info[0] <= icache_req_info_miss;
      if (w_capture[1]) r_pend_info[1] <= dcache_req_info_miss;

      if (w_grant) begin
        r_act_info   <= r_pend_info[w_grant_id];
        r_act_id     <= w_grant_id;
        r_last_grant <= w_grant_id;
      end

      if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_rsp_take) begin
        r_rsp_data <= r_act_info[148] ? '0 : mem_rsp_data;
        r_rsp_err  <= mem_rsp_error;
        r_rsp_id   <= r_act_id;
      end else if (w_timeout) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
        r_rsp_id   <= r_act_id;
      end
    end
  end

  assign mem_req_we    = r_act_info[148];
  assign mem_req_addr  = r_act_info[147:128];
  assign mem_req_wdata = r_act_info[127:0];
  assign rsp_data_miss = r_rsp_data;
  assign rsp_bus_error = r_rsp_err;
  assign rsp_cache_id  = r_rsp_id;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_core_mem_arbiter;

  localparam int unsigned TmoCycles = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         icache_req_valid_miss;
  logic [148:0] icache_req_info_miss;
  logic         dcache_req_valid_miss;
  logic [148:0] dcache_req_info_miss;
  logic [127:0] rsp_data_miss;
  logic         rsp_bus_error;
  logic         rsp_valid_miss;
  logic         rsp_cache_id;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_we;
  logic [19:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_rsp_valid;
  logic [127:0] mem_rsp_data;
  logic         mem_rsp_error;

  always #5 clock = ~clock;

  core_mem_arbiter #(
    .TIMEOUT_CYCLES(TmoCycles),
    .CNT_W         (4)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .icache_req_valid_miss(icache_req_valid_miss),
    .icache_req_info_miss (icache_req_info_miss),
    .dcache_req_valid_miss(dcache_req_valid_miss),
    .dcache_req_info_miss (dcache_req_info_miss),
    .rsp_data_miss        (rsp_data_miss),
    .rsp_bus_error        (rsp_bus_error),
    .rsp_valid_miss       (rsp_valid_miss),
    .rsp_cache_id         (rsp_cache_id),
    .mem_req_valid        (mem_req_valid),
    .mem_req_ready        (mem_req_ready),
    .mem_req_we           (mem_req_we),
    .mem_req_addr         (mem_req_addr),
    .mem_req_wdata        (mem_req_wdata),
    .mem_rsp_valid        (mem_rsp_valid),
    .mem_rsp_data         (mem_rsp_data),
    .mem_rsp_error        (mem_rsp_error)
  );

  typedef struct {
    bit           dc;
    bit           we;
    logic [19:0]  addr;
    logic [127:0] wdata;
    int           rdy_dly;
    int           rsp_dly;
    bit           tmo;
    logic [127:0] rdata;
    bit           rerr;
    logic [127:0] exp_data;
    bit           exp_err;
    bit           exp_id;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b, expected %0b", name, act, exp);
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    icache_req_valid_miss = 1'b0;
    icache_req_info_miss  = '0;
    dcache_req_valid_miss = 1'b0;
    dcache_req_info_miss  = '0;
    mem_req_ready         = 1'b0;
    mem_rsp_valid         = 1'b0;
    mem_rsp_data          = '0;
    mem_rsp_error         = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk_b({tag, "_mem_req_valid"}, mem_req_valid, 1'b0);
    chk_b({tag, "_mem_req_we"}, mem_req_we, 1'b0);
    chk_w({tag, "_mem_req_addr"}, 128'(mem_req_addr), '0);
    chk_w({tag, "_mem_req_wdata"}, mem_req_wdata, '0);
    chk_b({tag, "_rsp_valid"}, rsp_valid_miss, 1'b0);
    chk_b({tag, "_rsp_err"}, rsp_bus_error, 1'b0);
    chk_b({tag, "_rsp_id"}, rsp_cache_id, 1'b0);
    chk_w({tag, "_rsp_data"}, rsp_data_miss, '0);
  endtask

  // One complete transaction from an idle arbiter; request starts in the current cycle.
  task automatic run_vec(input int idx, input vec_t v);
    logic [148:0] info;
    int           n;
    info = {v.we, v.addr, v.wdata};
    if (v.dc) begin
      dcache_req_valid_miss = 1'b1;
      dcache_req_info_miss  = info;
    end else begin
      icache_req_valid_miss = 1'b1;
      icache_req_info_miss  = info;
    end
    n = 0;
    do begin
      step();
      n++;
    end while (!mem_req_valid && n < 10);
    chk_i($sformatf("v%0d_issue_latency", idx), n, 2);
    for (int i = 0; i <= v.rdy_dly; i++) begin
      chk_b($sformatf("v%0d_mem_req_valid", idx), mem_req_valid, 1'b1);
      chk_w($sformatf("v%0d_mem_req_addr", idx), 128'(mem_req_addr), 128'(v.addr));
      chk_w($sformatf("v%0d_mem_req_wdata", idx), mem_req_wdata, v.wdata);
      chk_b($sformatf("v%0d_mem_req_we", idx), mem_req_we, v.we);
      if (i == v.rdy_dly) mem_req_ready = 1'b1;
      step();
    end
    mem_req_ready = 1'b0;
    chk_b($sformatf("v%0d_req_drop", idx), mem_req_valid, 1'b0);
    if (v.tmo) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!rsp_valid_miss && n < 20);
      chk_i($sformatf("v%0d_timeout_cycles", idx), n, TmoCycles);
    end else begin
      for (int i = 0; i < v.rsp_dly; i++) begin
        chk_b($sformatf("v%0d_early_rsp", idx), rsp_valid_miss, 1'b0);
        step();
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = v.rdata;
      mem_rsp_error = v.rerr;
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_error = 1'b0;
      chk_b($sformatf("v%0d_rsp_valid", idx), rsp_valid_miss, 1'b1);
    end
    chk_b($sformatf("v%0d_rsp_id", idx), rsp_cache_id, v.exp_id);
    chk_w($sformatf("v%0d_rsp_data", idx), rsp_data_miss, v.exp_data);
    chk_b($sformatf("v%0d_rsp_err", idx), rsp_bus_error, v.exp_err);
    icache_req_valid_miss = 1'b0;
    dcache_req_valid_miss = 1'b0;
    step();
    chk_b($sformatf("v%0d_rsp_one_cycle", idx), rsp_valid_miss, 1'b0);
    chk_w($sformatf("v%0d_rsp_data_held", idx), rsp_data_miss, v.exp_data);
    chk_b($sformatf("v%0d_rsp_id_held", idx), rsp_cache_id, v.exp_id);
    if (v.tmo) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = '1;
      step();
      mem_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk_b($sformatf("v%0d_stray_rsp", idx), rsp_valid_miss, 1'b0);
        step();
      end
    end
  endtask

  // Model: a grant goes to the earliest-started request (tie -> the source not granted last),
  // issued 2 cycles after its start and no earlier than 2 cycles after the previous response.
  task automatic run_random(input int ncyc);
    bit           act [2];
    int           start [2];
    logic [148:0] info [2];
    int           gap [2];
    int           last_g = 1;
    int           prev_resp = -100;
    int           ph = 0;
    int           cur = 0;
    int           rdy_cnt = 0;
    int           w_first = 0;
    int           rsp_at = 0;
    int           exp_rc = 0;
    int           win = 0;
    int           exp_iss = 0;
    bit           to = 1'b0;
    bit           grant_now;
    bit           exp_rv;
    bit           exp_mv;
    bit           rerr = 1'b0;
    bit           exp_err = 1'b0;
    logic [127:0] rdata = '0;
    logic [127:0] exp_data = '0;
    for (int s = 0; s < 2; s++) begin
      act[s]   = 1'b0;
      start[s] = 0;
      info[s]  = '0;
      gap[s]   = 0;
    end
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      exp_rv = (ph == 2) && (cyc == exp_rc);
      chk_b("rnd_rsp_valid", rsp_valid_miss, exp_rv);
      if (exp_rv) begin
        chk_b("rnd_rsp_id", rsp_cache_id, 1'(cur));
        chk_w("rnd_rsp_data", rsp_data_miss, exp_data);
        chk_b("rnd_rsp_err", rsp_bus_error, exp_err);
        act[cur]  = 1'b0;
        gap[cur]  = $urandom_range(5, 1);
        prev_resp = cyc;
        ph        = 0;
      end
      grant_now = 1'b0;
      if (ph == 0 && (act[0] || act[1])) begin
        if (act[0] && act[1]) begin
          if (start[0] < start[1]) win = 0;
          else if (start[1] < start[0]) win = 1;
          else win = 1 - last_g;
        end else begin
          win = act[1] ? 1 : 0;
        end
        exp_iss = start[win] + 2;
        if (prev_resp + 2 > exp_iss) exp_iss = prev_resp + 2;
        grant_now = (cyc == exp_iss);
      end
      exp_mv = (ph == 1) || grant_now;
      chk_b("rnd_mem_req_valid", mem_req_valid, exp_mv);
      if (grant_now) begin
        cur     = win;
        last_g  = win;
        ph      = 1;
        rdy_cnt = $urandom_range(3, 0);
      end
      if (ph == 1) begin
        chk_w("rnd_mem_req_addr", 128'(mem_req_addr), 128'(info[cur][147:128]));
        chk_w("rnd_mem_req_wdata", mem_req_wdata, info[cur][127:0]);
        chk_b("rnd_mem_req_we", mem_req_we, info[cur][148]);
      end

      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
      mem_rsp_error = 1'($urandom_range(1, 0));
      if (ph == 1) begin
        if (rdy_cnt == 0) begin
          mem_req_ready = 1'b1;
          ph            = 2;
          w_first       = cyc + 1;
          to            = ($urandom_range(5, 0) == 0);
          rdata         = {$urandom, $urandom, $urandom, $urandom};
          rerr          = ($urandom_range(3, 0) == 0);
          if (to) begin
            exp_rc   = w_first + TmoCycles;
            exp_data = '0;
            exp_err  = 1'b1;
          end else begin
            rsp_at   = w_first + $urandom_range(TmoCycles - 1, 0);
            exp_rc   = rsp_at + 1;
            exp_data = info[cur][148] ? '0 : rdata;
            exp_err  = rerr;
          end
        end else begin
          rdy_cnt--;
        end
      end else if (ph == 2) begin
        if (!to && cyc == rsp_at) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = rdata;
          mem_rsp_error = rerr;
        end
      end
      if (ph != 2 && $urandom_range(7, 0) == 0) mem_rsp_valid = 1'b1;

      for (int s = 0; s < 2; s++) begin
        if (!act[s]) begin
          if (gap[s] > 0) begin
            gap[s]--;
          end else if ($urandom_range(2, 0) == 0) begin
            act[s]   = 1'b1;
            start[s] = cyc;
            info[s]  = {1'($urandom_range(1, 0)), 20'($urandom), $urandom, $urandom, $urandom,
                        $urandom};
          end
        end
      end
      icache_req_valid_miss = act[0];
      icache_req_info_miss  = info[0];
      dcache_req_valid_miss = act[1];
      dcache_req_info_miss  = info[1];
      step();
    end
    idle_in();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [7];
    int   n;
    vecs[0] = '{0, 0, 20'h00040, '0, 0, 3, 0, {16{8'hA5}}, 0, {16{8'hA5}}, 0, 0};
    vecs[1] = '{1, 1, 20'h00123, {4{32'hDEADBEEF}}, 5, 1, 0, 128'h1234, 0, '0, 0, 1};
    vecs[2] = '{0, 0, 20'h00ABC, '0, 0, 0, 1, '0, 0, '0, 1, 0};
    vecs[3] = '{1, 0, 20'h00200, '0, 1, 2, 0, {4{32'h77777777}}, 1, {4{32'h77777777}}, 1, 1};
    vecs[4] = '{1, 0, 20'h00201, '0, 0, 0, 0, 128'hCAFE, 0, 128'hCAFE, 0, 1};
    vecs[5] = '{0, 0, 20'hFFFFF, '0, 2, 7, 0, {8{16'h5A5A}}, 0, {8{16'h5A5A}}, 0, 0};
    vecs[6] = '{1, 1, 20'h00010, {4{32'h0BADF00D}}, 0, 0, 1, '0, 0, '0, 1, 1};

    do_reset();
    chk_zero("rst");

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset during WAIT with a dcache request latched behind the icache transaction.
    icache_req_valid_miss = 1'b1;
    icache_req_info_miss  = {1'b0, 20'h00333, 128'h0};
    n = 0;
    while (!mem_req_valid && n < 10) begin
      step();
      n++;
    end
    chk_i("wrst_issue_latency", n, 2);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready         = 1'b0;
    dcache_req_valid_miss = 1'b1;
    dcache_req_info_miss  = {1'b0, 20'h00444, 128'h0};
    step();
    step();
    reset                 = 1'b1;
    icache_req_valid_miss = 1'b0;
    dcache_req_valid_miss = 1'b0;
    step();
    chk_zero("wrst");
    reset         = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = '1;
    step();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_b("wrst_no_rsp", rsp_valid_miss, 1'b0);
      chk_b("wrst_no_grant", mem_req_valid, 1'b0);
      step();
    end

    // Both sources requesting together and held: icache first, then strict alternation.
    do_reset();
    icache_req_valid_miss = 1'b1;
    icache_req_info_miss  = {1'b0, 20'h00111, 128'h0};
    dcache_req_valid_miss = 1'b1;
    dcache_req_info_miss  = {1'b0, 20'h00222, 128'h0};
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!mem_req_valid && n < 10) begin
        step();
        n++;
      end
      chk_i("alt_grant_spacing", n, 2);
      chk_w("alt_addr", 128'(mem_req_addr), (k % 2 == 0) ? 128'h111 : 128'h222);
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 128'(k + 1);
      step();
      mem_rsp_valid = 1'b0;
      chk_b("alt_rsp_valid", rsp_valid_miss, 1'b1);
      chk_b("alt_rsp_id", rsp_cache_id, 1'(k % 2));
      chk_w("alt_rsp_data", rsp_data_miss, 128'(k + 1));
    end

    do_reset();
    run_random(3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
